fetch_pc_unit: RTL and testbench

Fetch stage that consumes the `io_pc_sel` code produced by the branch logic and owns the architectural fetch PC. Each cycle it resolves the next PC from the selected target, issues at most one outstanding instruction-memory request, and buffers returned instructions in a 2-entry queue feeding decode. Redirects (branch, jump, jalr, exception) flush the queue and discard any in-flight response.

---
 rtl/fetch_pc_unit.sv | 126 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the fetch PC, keeps one instruction-memory request in flight
// and buffers returned words in a 2-entry queue toward decode.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_exe_valid,
    input  logic [2:0]  io_pc_sel,
    input  logic [31:0] io_br_target,
    input  logic [31:0] io_jmp_target,
    input  logic [31:0] io_jalr_target,
    input  logic [31:0] io_evec,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [31:0] io_imem_req_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    output logic        io_dec_valid,
    input  logic        io_dec_ready,
    output logic [31:0] io_dec_inst,
    output logic [31:0] io_dec_pc,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_REQ       = 2'd1;
    localparam logic [1:0] S_WAIT      = 2'd2;
    localparam logic [1:0] S_WAIT_KILL = 2'd3;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // req_valid is never withdrawn before its transfer except by a redirect.
    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [1:0]  r_count;
    logic        r_head;
    logic [31:0] r_q_pc   [2];
    logic [31:0] r_q_inst [2];

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_req_valid;
    logic        w_hs;
    logic        w_push;
    logic        w_dec_valid;
    logic        w_pop;
    logic        w_tail;
    logic [1:0]  w_state_nxt;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = '0;
        if (io_exe_valid) begin
            case (io_pc_sel)
                3'd1: begin w_redirect = 1'b1; w_target = io_jalr_target; end
                3'd2: begin w_redirect = 1'b1; w_target = io_br_target;   end
                3'd3: begin w_redirect = 1'b1; w_target = io_jmp_target;  end
                3'd4: begin w_redirect = 1'b1; w_target = io_evec;        end
                default: begin w_redirect = 1'b0; w_target = '0; end
            endcase
        end
    end

    assign w_req_valid = (r_state == S_REQ) && (r_count < 2'd2);
    assign w_hs        = w_req_valid && io_imem_req_ready;
    // A response landing in the redirect cycle belongs to the old path.
    assign w_push      = (r_state == S_WAIT) && io_imem_resp_valid && !w_redirect;
    assign w_dec_valid = (r_count != 2'd0) && !w_redirect;
    assign w_pop       = w_dec_valid && io_dec_ready;
    assign w_tail      = r_head ^ r_count[0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      w_state_nxt = S_REQ;
            S_REQ:       if (w_hs) w_state_nxt = w_redirect ? S_WAIT_KILL : S_WAIT;
            S_WAIT: begin
                if (io_imem_resp_valid)  w_state_nxt = S_REQ;
                else if (w_redirect)     w_state_nxt = S_WAIT_KILL;
            end
            S_WAIT_KILL: if (io_imem_resp_valid) w_state_nxt = S_REQ;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= '0;
            r_count     <= '0;
            r_head      <= 1'b0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
            r_q_inst[0] <= '0;
            r_q_inst[1] <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_redirect)  r_fetch_pc <= w_target;
            else if (w_hs)   r_fetch_pc <= r_fetch_pc + 32'd4;

            if (w_hs) r_req_pc <= r_fetch_pc;

            if (w_push) begin
                r_q_pc[w_tail]   <= r_req_pc;
                r_q_inst[w_tail] <= io_imem_resp_data;
            end

            if (w_pop) r_head <= ~r_head;

            if (w_redirect)             r_count <= 2'd0;
            else if (w_push && !w_pop)  r_count <= r_count + 2'd1;
            else if (!w_push && w_pop)  r_count <= r_count - 2'd1;
        end
    end

    assign io_imem_req_valid = w_req_valid;
    assign io_imem_req_addr  = r_fetch_pc;
    assign io_dec_valid      = w_dec_valid;
    assign io_dec_inst       = r_q_inst[r_head];
    assign io_dec_pc         = r_q_pc[r_head];
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: behavioural memory with programmable latency and
// request budget, plus a scoreboard of expected {pc, inst} pairs seen by decode.
module tb_fetch_pc_unit;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_WAIT_KILL = 2'd3;

  logic        clk;
  logic        reset_n;
  logic        io_exe_valid;
  logic [2:0]  io_pc_sel;
  logic [31:0] io_br_target, io_jmp_target, io_jalr_target, io_evec;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_dec_valid;
  logic        io_dec_ready;
  logic [31:0] io_dec_inst;
  logic [31:0] io_dec_pc;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  int          hs_left = 0;
  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  fetch_pc_unit dut (
    .clk(clk), .reset_n(reset_n),
    .io_exe_valid(io_exe_valid), .io_pc_sel(io_pc_sel),
    .io_br_target(io_br_target), .io_jmp_target(io_jmp_target),
    .io_jalr_target(io_jalr_target), .io_evec(io_evec),
    .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_addr(io_imem_req_addr),
    .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_data(io_imem_resp_data),
    .io_dec_valid(io_dec_valid), .io_dec_ready(io_dec_ready),
    .io_dec_inst(io_dec_inst), .io_dec_pc(io_dec_pc),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, word_of(pc)});
  endtask

  // Memory: drives ready/resp at posedge+2, samples the upcoming handshake at negedge.
  initial begin
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      io_imem_resp_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          io_imem_resp_valid = 1'b1;
          io_imem_resp_data  = word_of(pend_addr);
        end
      end
      io_imem_req_ready = (hs_left > 0);
      @(negedge clk);
      if (reset_n && io_imem_req_valid && io_imem_req_ready) begin
        pend_addr = io_imem_req_addr;
        pend_cnt  = mem_lat;
        hs_left   = hs_left - 1;
      end
    end
  end

  // Scoreboard: every instruction decode accepts must be the next expected one.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && io_dec_valid && io_dec_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL dec_unexpected: got pc=%h inst=%h, required no instruction", io_dec_pc, io_dec_inst);
        end else begin
          e = exp_q.pop_front();
          if ({io_dec_pc, io_dec_inst} !== e) begin
            failures++;
            $display("FAIL dec_pair: got pc=%h inst=%h, required pc=%h inst=%h",
                     io_dec_pc, io_dec_inst, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    cyc();
    reset_n = 1'b0;
    io_exe_valid = 1'b0;
    io_pc_sel = 3'd0;
    io_dec_ready = 1'b0;
    pend_cnt = 0;
    hs_left = 0;
    mem_lat = 1;
    exp_q.delete();
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
    repeat (3) cyc();
    half();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc();
    reset_n = 1'b0;
    half();
    checks++;
    if ({io_imem_req_valid, io_imem_req_addr, io_dec_valid, io_dec_inst, io_dec_pc, o_dbg_state}
        !== {1'b0, 32'h2000, 1'b0, 32'h0, 32'h0, S_IDLE}) begin
      failures++;
      $display("FAIL reset_values: got rv=%b addr=%h dv=%b inst=%h pc=%h st=%0d, required 0 2000 0 0 0 0",
               io_imem_req_valid, io_imem_req_addr, io_dec_valid, io_dec_inst, io_dec_pc, o_dbg_state);
    end
    cyc();
    reset_n = 1'b1;
    half();
    checks++;
    if ({io_imem_req_valid, o_dbg_state} !== {1'b0, S_IDLE}) begin
      failures++;
      $display("FAIL cycle0_idle: got rv=%b st=%0d, required rv=0 st=0", io_imem_req_valid, o_dbg_state);
    end
    cyc();
    half();
    checks++;
    if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 32'h2000}) begin
      failures++;
      $display("FAIL cycle1_req: got rv=%b addr=%h, required rv=1 addr=00002000", io_imem_req_valid, io_imem_req_addr);
    end
  endtask

  task automatic test_basic();
    logic        exp_v;
    logic [31:0] exp_a;
    do_reset();
    hs_left = 3;
    io_dec_ready = 1'b1;
    push_exp(32'h2000); push_exp(32'h2004); push_exp(32'h2008);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      half();
      exp_v = (c % 2 == 1);
      exp_a = 32'h2000 + 32'((c - 1) / 2) * 32'd4;
      checks++;
      if (io_imem_req_valid !== exp_v || (exp_v && io_imem_req_addr !== exp_a)) begin
        failures++;
        $display("FAIL basic_req_c%0d: got rv=%b addr=%h, required rv=%b addr=%h",
                 c, io_imem_req_valid, io_imem_req_addr, exp_v, exp_a);
      end
    end
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 32'h200C}) begin
        failures++;
        $display("FAIL basic_hold: got rv=%b addr=%h, required rv=1 addr=0000200c", io_imem_req_valid, io_imem_req_addr);
      end
      cyc();
      half();
    end
  endtask

  task automatic test_stall();
    do_reset();
    hs_left = 3;
    io_dec_ready = 1'b0;
    push_exp(32'h2000); push_exp(32'h2004); push_exp(32'h2008);
    repeat (5) cyc();
    for (int i = 0; i < 4; i++) begin
      half();
      checks++;
      if ({io_imem_req_valid, o_dbg_state} !== {1'b0, S_REQ}) begin
        failures++;
        $display("FAIL stall_full: got rv=%b st=%0d, required rv=0 st=1", io_imem_req_valid, o_dbg_state);
      end
      cyc();
    end
    io_dec_ready = 1'b1;
    half();
    cyc();
    io_dec_ready = 1'b0;
    half();
    checks++;
    if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 32'h2008}) begin
      failures++;
      $display("FAIL stall_resume: got rv=%b addr=%h, required rv=1 addr=00002008", io_imem_req_valid, io_imem_req_addr);
    end
    checks++;
    if (exp_q.size() != 2) begin
      failures++;
      $display("FAIL stall_one_pop: got %0d pending, required 2", exp_q.size());
    end
    repeat (2) cyc();
    io_dec_ready = 1'b1;
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0 || io_imem_req_addr !== 32'h200C) begin
      failures++;
      $display("FAIL stall_drain: got pending=%0d addr=%h, required 0 0000200c", exp_q.size(), io_imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    hs_left = 3;
    mem_lat = 3;
    io_dec_ready = 1'b1;
    io_br_target = 32'h3000;
    push_exp(32'h3000); push_exp(32'h3004);
    cyc();
    cyc();
    io_exe_valid = 1'b1;
    io_pc_sel = 3'd2;
    half();
    checks++;
    if ({o_dbg_state, io_dec_valid} !== {S_WAIT, 1'b0}) begin
      failures++;
      $display("FAIL rdw_wait: got st=%0d dv=%b, required st=2 dv=0", o_dbg_state, io_dec_valid);
    end
    cyc();
    io_exe_valid = 1'b0;
    io_pc_sel = 3'd0;
    half();
    checks++;
    if ({o_dbg_state, io_imem_req_valid} !== {S_WAIT_KILL, 1'b0}) begin
      failures++;
      $display("FAIL rdw_kill: got st=%0d rv=%b, required st=3 rv=0", o_dbg_state, io_imem_req_valid);
    end
    cyc();
    mem_lat = 1;
    cyc();
    half();
    checks++;
    if ({o_dbg_state, io_imem_req_valid, io_imem_req_addr} !== {S_REQ, 1'b1, 32'h3000}) begin
      failures++;
      $display("FAIL rdw_target: got st=%0d rv=%b addr=%h, required st=1 rv=1 addr=00003000",
               o_dbg_state, io_imem_req_valid, io_imem_req_addr);
    end
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0 || io_imem_req_addr !== 32'h3008) begin
      failures++;
      $display("FAIL rdw_drain: got pending=%0d addr=%h, required 0 00003008", exp_q.size(), io_imem_req_addr);
    end
  endtask

  task automatic test_redirect_handshake();
    do_reset();
    hs_left = 3;
    io_dec_ready = 1'b1;
    io_jmp_target = 32'h4000;
    push_exp(32'h4000); push_exp(32'h4004);
    cyc();
    io_exe_valid = 1'b1;
    io_pc_sel = 3'd3;
    half();
    checks++;
    if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 32'h2000}) begin
      failures++;
      $display("FAIL rdh_stands: got rv=%b addr=%h, required rv=1 addr=00002000", io_imem_req_valid, io_imem_req_addr);
    end
    cyc();
    io_exe_valid = 1'b0;
    io_pc_sel = 3'd0;
    half();
    checks++;
    if (o_dbg_state !== S_WAIT_KILL) begin
      failures++;
      $display("FAIL rdh_kill: got st=%0d, required st=3", o_dbg_state);
    end
    cyc();
    half();
    checks++;
    if ({o_dbg_state, io_imem_req_valid, io_imem_req_addr} !== {S_REQ, 1'b1, 32'h4000}) begin
      failures++;
      $display("FAIL rdh_target: got st=%0d rv=%b addr=%h, required st=1 rv=1 addr=00004000",
               o_dbg_state, io_imem_req_valid, io_imem_req_addr);
    end
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0 || io_imem_req_addr !== 32'h4008) begin
      failures++;
      $display("FAIL rdh_drain: got pending=%0d addr=%h, required 0 00004008", exp_q.size(), io_imem_req_addr);
    end
  endtask

  task automatic test_sel_codes();
    logic        t_ev  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0]  t_sel [9] = '{3'd2, 3'd6, 3'd5, 3'd7, 3'd0, 3'd1, 3'd3, 3'd2, 3'd4};
    logic [31:0] t_adr [9] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100,
                               32'h5000, 32'h4000, 32'h3000, 32'h100};
    do_reset();
    hs_left = 1;
    io_dec_ready = 1'b0;
    io_br_target = 32'h3000;
    io_jmp_target = 32'h4000;
    io_jalr_target = 32'h5000;
    io_evec = 32'h100;
    repeat (3) cyc();
    half();
    checks++;
    if ({io_dec_valid, io_dec_pc, io_dec_inst} !== {1'b1, 32'h2000, word_of(32'h2000)}) begin
      failures++;
      $display("FAIL sel_head: got dv=%b pc=%h inst=%h, required dv=1 pc=00002000 inst=%h",
               io_dec_valid, io_dec_pc, io_dec_inst, word_of(32'h2000));
    end
    cyc();
    io_exe_valid = 1'b1;
    io_pc_sel = 3'd4;
    io_dec_ready = 1'b1;
    half();
    checks++;
    if (io_dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL sel_dec_masked: got dv=%b, required dv=0", io_dec_valid);
    end
    cyc();
    io_exe_valid = 1'b0;
    io_pc_sel = 3'd0;
    half();
    checks++;
    if ({io_dec_valid, io_imem_req_valid, io_imem_req_addr} !== {1'b0, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL sel_evec: got dv=%b rv=%b addr=%h, required dv=0 rv=1 addr=00000100",
               io_dec_valid, io_imem_req_valid, io_imem_req_addr);
    end
    for (int i = 0; i < 9; i++) begin
      cyc();
      io_exe_valid = t_ev[i];
      io_pc_sel = t_sel[i];
      cyc();
      io_exe_valid = 1'b0;
      io_pc_sel = 3'd0;
      half();
      checks++;
      if (io_imem_req_addr !== t_adr[i]) begin
        failures++;
        $display("FAIL sel_code_%0d: ev=%b sel=%0d got addr=%h, required %h",
                 i, t_ev[i], t_sel[i], io_imem_req_addr, t_adr[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hs_left = 3;
    io_dec_ready = 1'b0;
    cyc();
    cyc();
    mem_lat = 3;
    cyc();
    cyc();
    half();
    checks++;
    if ({o_dbg_state, io_dec_valid, io_dec_pc} !== {S_WAIT, 1'b1, 32'h2000}) begin
      failures++;
      $display("FAIL rmw_before: got st=%0d dv=%b pc=%h, required st=2 dv=1 pc=00002000",
               o_dbg_state, io_dec_valid, io_dec_pc);
    end
    cyc();
    reset_n = 1'b0;
    pend_cnt = 0;
    hs_left = 0;
    #1;
    checks++;
    if ({io_imem_req_valid, io_imem_req_addr, io_dec_valid, io_dec_inst, io_dec_pc, o_dbg_state}
        !== {1'b0, 32'h2000, 1'b0, 32'h0, 32'h0, S_IDLE}) begin
      failures++;
      $display("FAIL rmw_async: got rv=%b addr=%h dv=%b inst=%h pc=%h st=%0d, required 0 2000 0 0 0 0",
               io_imem_req_valid, io_imem_req_addr, io_dec_valid, io_dec_inst, io_dec_pc, o_dbg_state);
    end
    repeat (2) cyc();
    reset_n = 1'b1;
    hs_left = 1;
    mem_lat = 1;
    io_dec_ready = 1'b1;
    push_exp(32'h2000);
    cyc();
    half();
    checks++;
    if ({io_imem_req_valid, io_imem_req_addr} !== {1'b1, 32'h2000}) begin
      failures++;
      $display("FAIL rmw_restart: got rv=%b addr=%h, required rv=1 addr=00002000", io_imem_req_valid, io_imem_req_addr);
    end
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rmw_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    io_exe_valid = 1'b0;
    io_pc_sel = 3'd0;
    io_br_target = '0;
    io_jmp_target = '0;
    io_jalr_target = '0;
    io_evec = '0;
    io_dec_ready = 1'b0;
    repeat (2) cyc();
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_handshake();
    test_sel_codes();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
